// File: rtl/arm7tdmi_pkg.sv
// Shared types for the ARM7TDMI core memory-side blocks.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/arm7tdmi_mem_arbiter.sv
// Fetch/data arbiter for the single core memory bus: data-priority with a
// fetch starvation limit, one transaction at a time, optional wait timeout.
module arm7tdmi_mem_arbiter
  import arm7tdmi_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_re,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_err,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);
  localparam logic [CNT_W-1:0] TMO_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_t       state_q, state_d;
  arb_owner_t       grant;
  logic [CNT_W-1:0] streak_q, tcnt_q;
  logic             abandon_q;
  logic             d_req, force_fetch, owner_req, tmo, done, deliver;

  assign d_req       = d_re | d_we;
  assign force_fetch = if_re && (MAX_STREAK != 0) && (streak_q == STREAK_MAX);
  assign busy        = (state_q != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch; blocking '=' is correct in combinational code.
  always_comb begin
    state_d   = state_q;
    grant     = OWN_NONE;
    owner_req = 1'b0;
    tmo       = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !force_fetch) begin
          grant   = OWN_D;
          state_d = BUSY_D;
        end else if (if_re) begin
          grant   = OWN_I;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        owner_req = (state_q == BUSY_I) ? if_re : d_req;
        // A mem_ready coinciding with the last timeout cycle completes normally.
        tmo       = (TIMEOUT != 0) && !mem_ready && (tcnt_q == TMO_LAST);
        done      = mem_ready || tmo;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A requester that dropped its request at any point during BUSY has left.
    deliver  = done && !abandon_q && owner_req && !rst;
    if_ready = deliver && (state_q == BUSY_I);
    d_ready  = deliver && (state_q == BUSY_D);
    if_err   = if_ready && tmo;
    d_err    = d_ready && tmo;
    if_rdata = (if_ready && !tmo) ? mem_rdata : 32'h0;
    d_rdata  = (d_ready && !tmo) ? mem_rdata : 32'h0;
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: this block holds only control/datapath flops, so every one of them
  // is reset; there is no storage array here that would justify skipping reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_size  <= '0;
      streak_q  <= '0;
      tcnt_q    <= '0;
      abandon_q <= 1'b0;
    end else begin
      unique case (grant)
        OWN_D: begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_size  <= d_size;
          mem_re    <= d_re;
          mem_we    <= d_we;
          tcnt_q    <= '0;
        end
        OWN_I: begin
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_size  <= 2'(WORD);
          mem_re    <= 1'b1;
          mem_we    <= 1'b0;
          tcnt_q    <= '0;
        end
        default: ;
      endcase

      if (state_q == IDLE) begin
        if (grant == OWN_I || !if_re)
          streak_q <= '0;
        else if (grant == OWN_D && streak_q != STREAK_MAX)
          streak_q <= streak_q + CNT_W'(1);
      end

      if (busy) begin
        if (done) begin
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          abandon_q <= 1'b0;
        end else begin
          if (!owner_req) abandon_q <= 1'b1;
          tcnt_q <= tcnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_arm7tdmi_mem_arbiter.sv
// Scoreboard bench for the fetch/data memory arbiter (MAX_STREAK=4, TIMEOUT=8).
module tb_arm7tdmi_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  size;
  } grant_t;

  typedef struct {
    bit          data;
    logic [31:0] rdata;
    logic        err;
  } cpl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_re = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready, if_err;
  logic        d_re = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_rdata;
  logic        d_ready, d_err;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  grant_t gq[$];
  cpl_t   cq[$];

  int lat = 2;
  bit mem_never = 1'b0;
  bit force_ready = 1'b0;
  int rcnt = 0;
  bit prev_strobe = 1'b0;

  arm7tdmi_mem_arbiter #(.MAX_STREAK(4), .TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_re(if_re), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_err(if_err),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hE3A0_0001;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: answers `lat` cycles after the strobe's first cycle.
  always @(posedge clk) begin
    #1;
    if ((mem_re || mem_we) && !mem_never) begin
      if (rcnt == lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_val(mem_addr);
      end else begin
        mem_ready = 1'b0;
        rcnt++;
      end
    end else begin
      mem_ready = force_ready && !(mem_re || mem_we);
      mem_rdata = force_ready ? 32'h1234_5678 : 32'h0;
      rcnt = 0;
    end
  end

  // Grant monitor: every strobe rising edge must match the next expected grant.
  always @(negedge clk) begin
    if ((mem_re || mem_we) && !prev_strobe) begin
      n_checks++;
      if (gq.size() == 0) begin
        $display("FAIL grant_unexpected: addr %h re %b we %b, none expected", mem_addr, mem_re, mem_we);
      end else begin
        grant_t g;
        g = gq.pop_front();
        if ({mem_addr, mem_re, mem_we, mem_wdata, mem_size} !== {g.addr, g.re, g.we, g.wdata, g.size})
          $display("FAIL grant: got addr %h re %b we %b wdata %h size %0d, exp addr %h re %b we %b wdata %h size %0d",
                   mem_addr, mem_re, mem_we, mem_wdata, mem_size, g.addr, g.re, g.we, g.wdata, g.size);
        else n_pass++;
      end
    end
    prev_strobe = mem_re || mem_we;
  end

  // Completion monitor: every ready pulse must match the next expected completion.
  always @(negedge clk) begin
    if (if_ready || d_ready) begin
      n_checks++;
      if (cq.size() == 0 || (if_ready && d_ready)) begin
        $display("FAIL cpl_unexpected: if_ready %b d_ready %b, exp none", if_ready, d_ready);
      end else begin
        cpl_t c;
        logic [31:0] own, other;
        logic        err;
        c = cq.pop_front();
        own   = d_ready ? d_rdata : if_rdata;
        other = d_ready ? if_rdata : d_rdata;
        err   = d_ready ? d_err : if_err;
        if ({d_ready, own, err, other} !== {c.data, c.rdata, c.err, 32'h0})
          $display("FAIL cpl: got data %b rdata %h err %b other %h, exp data %b rdata %h err %b other 0",
                   d_ready, own, err, other, c.data, c.rdata, c.err);
        else n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input logic [31:0] a, input logic re, input logic we,
                            input logic [31:0] wd, input logic [1:0] sz);
    grant_t g;
    g.addr = a; g.re = re; g.we = we; g.wdata = wd; g.size = sz;
    gq.push_back(g);
  endtask

  task automatic push_cpl(input bit data, input logic [31:0] rd, input logic err);
    cpl_t c;
    c.data = data; c.rdata = rd; c.err = err;
    cq.push_back(c);
  endtask

  task automatic wait_ready(input bit data_port, input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (data_port ? d_ready : if_ready) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({if_rdata, if_ready, if_err, d_rdata, d_ready, d_err, mem_addr, mem_re, mem_we, mem_wdata, mem_size, busy} !== '0)
      $display("FAIL reset_outputs: got busy %b mem_re %b mem_we %b mem_addr %h, exp all 0", busy, mem_re, mem_we, mem_addr);
    else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_re, mem_we, if_ready, d_ready} !== 5'b0)
      $display("FAIL post_reset_idle: got %b, exp 00000", {busy, mem_re, mem_we, if_ready, d_ready});
    else n_pass++;
  endtask

  task automatic test_fetch_only();
    int cyc;
    lat = 2;
    push_grant(32'h100, 1'b1, 1'b0, 32'h0, 2'd2);
    push_cpl(1'b0, 32'hE3A0_0001, 1'b0);
    tick();
    if_re = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (mem_re !== 1'b0) $display("FAIL fetch_no_early_strobe: got %b exp 0", mem_re); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({mem_re, mem_addr, mem_size} !== {1'b1, 32'h100, 2'd2})
      $display("FAIL fetch_strobe: got re %b addr %h size %0d, exp re 1 addr 100 size 2", mem_re, mem_addr, mem_size);
    else n_pass++;
    wait_ready(1'b0, 10, cyc);
    n_checks++;
    if (cyc !== 2) $display("FAIL fetch_latency: got %0d exp 2", cyc); else n_pass++;
    tick();
    if_re = 1'b0;
    cyc = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_ready) cyc++;
    end
    n_checks++;
    if (cyc !== 0) $display("FAIL fetch_single_pulse: got %0d extra pulses exp 0", cyc); else n_pass++;
  endtask

  task automatic test_data_priority();
    int cyc;
    lat = 1;
    push_grant(32'h8000, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd2);
    push_grant(32'h200, 1'b1, 1'b0, 32'h0, 2'd2);
    push_cpl(1'b1, mem_val(32'h8000), 1'b0);
    push_cpl(1'b0, mem_val(32'h200), 1'b0);
    tick();
    if_re = 1'b1; if_addr = 32'h200;
    d_we = 1'b1; d_addr = 32'h8000; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
    wait_ready(1'b1, 10, cyc);
    n_checks++;
    if (cyc !== 3) $display("FAIL data_first_latency: got %0d exp 3", cyc); else n_pass++;
    tick();
    d_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_re, mem_we} !== 3'b000)
      $display("FAIL idle_bubble: got busy/re/we %b exp 000", {busy, mem_re, mem_we});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({mem_re, mem_we} !== 2'b10) $display("FAIL fetch_after_data: got re/we %b exp 10", {mem_re, mem_we}); else n_pass++;
    wait_ready(1'b0, 10, cyc);
    n_checks++;
    if (cyc !== 1) $display("FAIL fetch_after_data_latency: got %0d exp 1", cyc); else n_pass++;
    tick();
    if_re = 1'b0;
  endtask

  task automatic test_starvation();
    int n = 0;
    int fpos = 0;
    bit di, dd;
    lat = 0;
    for (int k = 0; k < 4; k++) push_grant(32'h4000, 1'b1, 1'b0, 32'h0, 2'd0);
    push_grant(32'h300, 1'b1, 1'b0, 32'h0, 2'd2);
    push_grant(32'h4000, 1'b1, 1'b0, 32'h0, 2'd0);
    for (int k = 0; k < 4; k++) push_cpl(1'b1, mem_val(32'h4000), 1'b0);
    push_cpl(1'b0, mem_val(32'h300), 1'b0);
    push_cpl(1'b1, mem_val(32'h4000), 1'b0);
    tick();
    d_re = 1'b1; d_addr = 32'h4000; d_size = 2'd0; d_wdata = 32'h0;
    if_re = 1'b1; if_addr = 32'h300;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      di = 1'b0; dd = 1'b0;
      if (if_ready) begin n++; fpos = n; di = 1'b1; end
      if (d_ready) begin n++; if (n == 6) dd = 1'b1; end
      tick();
      if (di) if_re = 1'b0;
      if (dd) d_re = 1'b0;
    end
    d_re = 1'b0; if_re = 1'b0;
    n_checks++;
    if (n !== 6) $display("FAIL starve_count: got %0d completions exp 6", n); else n_pass++;
    n_checks++;
    if (fpos !== 5) $display("FAIL starve_fetch_slot: got %0d exp 5", fpos); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abandon();
    int bad = 0;
    int rdy = 0;
    lat = 4;
    push_grant(32'h400, 1'b1, 1'b0, 32'h0, 2'd2);
    tick();
    if_re = 1'b1; if_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_re !== 1'b1) $display("FAIL abandon_grant: got %b exp 1", mem_re); else n_pass++;
    tick();
    if_re = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_re !== 1'b1 || busy !== 1'b1) bad++;
      if (if_ready) rdy++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL abandon_hold: got %0d cycles dropped exp 0", bad); else n_pass++;
    n_checks++;
    if (rdy !== 0) $display("FAIL abandon_no_ready: got %0d pulses exp 0", rdy); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_re} !== 2'b00) $display("FAIL abandon_release: got busy/re %b exp 00", {busy, mem_re}); else n_pass++;
  endtask

  task automatic test_timeout();
    int hi = 0;
    int cyc;
    mem_never = 1'b1;
    push_grant(32'h500, 1'b1, 1'b0, 32'h0, 2'd1);
    push_cpl(1'b1, 32'h0, 1'b1);
    tick();
    d_re = 1'b1; d_addr = 32'h500; d_size = 2'd1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_re) hi++;
      if (i == 8) begin
        n_checks++;
        if ({d_ready, d_err, d_rdata} !== {1'b1, 1'b1, 32'h0})
          $display("FAIL timeout_pulse: got ready %b err %b rdata %h exp 1 1 0", d_ready, d_err, d_rdata);
        else n_pass++;
      end
    end
    tick();
    d_re = 1'b0; mem_never = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_re) hi++;
    end
    n_checks++;
    if (hi !== 8) $display("FAIL timeout_strobe_len: got %0d exp 8", hi); else n_pass++;
    lat = 1;
    push_grant(32'h600, 1'b1, 1'b0, 32'h0, 2'd2);
    push_cpl(1'b0, mem_val(32'h600), 1'b0);
    tick();
    if_re = 1'b1; if_addr = 32'h600;
    wait_ready(1'b0, 10, cyc);
    n_checks++;
    if (cyc !== 3) $display("FAIL after_timeout_fetch: got %0d exp 3", cyc); else n_pass++;
    tick();
    if_re = 1'b0;
  endtask

  task automatic test_idle_ready();
    int bad = 0;
    tick();
    force_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if ({if_ready, d_ready, busy, if_rdata, d_rdata} !== '0) bad++;
    end
    tick();
    force_ready = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL idle_mem_ready: got %0d bad cycles exp 0", bad); else n_pass++;
  endtask

  task automatic test_reset_busy();
    int rdy = 0;
    lat = 5;
    push_grant(32'h700, 1'b1, 1'b0, 32'h0, 2'd2);
    tick();
    d_re = 1'b1; d_addr = 32'h700; d_size = 2'd2;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rst_busy_pre: got %b exp 1", busy); else n_pass++;
    tick();
    rst = 1'b1; d_re = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_rdata, if_ready, if_err, d_rdata, d_ready, d_err, mem_addr, mem_re, mem_we, mem_wdata, mem_size, busy} !== '0)
      $display("FAIL rst_busy_outputs: got busy %b mem_re %b mem_addr %h, exp all 0", busy, mem_re, mem_addr);
    else n_pass++;
    repeat (6) begin
      @(negedge clk);
      if (d_ready || mem_re) rdy++;
    end
    n_checks++;
    if (rdy !== 0) $display("FAIL rst_busy_quiet: got %0d active cycles exp 0", rdy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_data_priority();
    test_starvation();
    test_abandon();
    test_timeout();
    test_idle_ready();
    test_reset_busy();
    repeat (2) @(negedge clk);
    n_checks++;
    if (gq.size() !== 0 || cq.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d grants %0d completions left exp 0 0", gq.size(), cq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
